// File: rtl/sram_fifo_ctrl_if.sv
// Push/pop handshake bundle for the SRAM-backed FIFO controller.
interface sram_fifo_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW:0]   level;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a single-port synchronous SRAM with a 2-entry output buffer.
// One SRAM access per cycle; reads are reserved against output-buffer space.
module sram_fifo_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          i_clock,
  input  logic          i_reset,
  sram_fifo_ctrl_if.slave bus,
  output logic [AW-1:0] o_sram_a,
  output logic [DW-1:0] o_sram_i,
  output logic          o_sram_csb,
  output logic          o_sram_web,
  output logic          o_sram_oeb,
  input  logic [DW-1:0] i_sram_o
);
  localparam int LW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_mem_cnt;
  logic          r_inflight;
  logic          r_wr_owed;
  logic [1:0]    r_ob_cnt;
  logic [DW-1:0] r_ob0;
  logic [DW-1:0] r_ob1;

  logic          w_full;
  logic          w_rd_issue;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_ob_left;
  logic [DW-1:0] w_ob0_nxt;
  logic [DW-1:0] w_ob1_nxt;

  assign w_full = r_mem_cnt[AW];

  // A read only goes out when the buffer slot it lands in is already reserved.
  assign w_rd_issue = !i_reset && (r_mem_cnt != '0) &&
                      ((r_ob_cnt + {1'b0, r_inflight}) < 2'd2) && !r_wr_owed;

  assign bus.in_ready  = !i_reset && !w_full && !w_rd_issue;
  assign w_push        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = !i_reset && (r_ob_cnt != 2'd0);
  assign bus.out_data  = r_ob0;
  assign w_pop         = bus.out_valid && bus.out_ready;
  assign bus.level     = i_reset ? '0
                       : r_mem_cnt + LW'(r_inflight) + LW'(r_ob_cnt);

  assign o_sram_a   = w_rd_issue ? r_rd_ptr : r_wr_ptr;
  assign o_sram_i   = bus.in_data;
  assign o_sram_csb = !(w_push || w_rd_issue);
  assign o_sram_web = !w_push;
  assign o_sram_oeb = i_reset;

  // Pop shifts first, then returning read data fills the first free slot.
  always_comb begin
    w_ob_left = r_ob_cnt - {1'b0, w_pop};
    w_ob0_nxt = w_pop ? r_ob1 : r_ob0;
    w_ob1_nxt = r_ob1;
    if (r_inflight) begin
      if (w_ob_left == 2'd0) w_ob0_nxt = i_sram_o;
      else                   w_ob1_nxt = i_sram_o;
    end
  end

  always_ff @(posedge i_clock) begin
    r_ob0 <= w_ob0_nxt;
    r_ob1 <= w_ob1_nxt;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_ob_cnt   <= 2'd0;
      r_wr_owed  <= 1'b0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_mem_cnt  <= r_mem_cnt + LW'(w_push) - LW'(w_rd_issue);
      r_inflight <= w_rd_issue;
      r_ob_cnt   <= w_ob_left + {1'b0, r_inflight};
      // A write refused because of a read gets the very next cycle.
      if (w_push)
        r_wr_owed <= 1'b0;
      else if (bus.in_valid && !bus.in_ready && !w_full)
        r_wr_owed <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: behavioural SRAM, queue scoreboard, directed and random traffic.
module tb_sram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sram_a;
  logic [7:0] sram_i;
  logic       sram_csb;
  logic       sram_web;
  logic       sram_oeb;
  logic [7:0] sram_o = 8'h00;
  logic [7:0] sram_mem [256];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  int unsigned wr_cnt = 0;
  int unsigned rd_cnt = 0;

  sram_fifo_ctrl_if #(.AW(8), .DW(8)) bus ();

  sram_fifo_ctrl #(.AW(8), .DW(8)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .bus        (bus.slave),
    .o_sram_a   (sram_a),
    .o_sram_i   (sram_i),
    .o_sram_csb (sram_csb),
    .o_sram_web (sram_web),
    .o_sram_oeb (sram_oeb),
    .i_sram_o   (sram_o)
  );

  always #5 clk = ~clk;

  // Synchronous single-port SRAM: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) sram_mem[sram_a] <= sram_i;
      else           sram_o <= sram_mem[sram_a];
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: held words = accepted minus popped; strict FIFO order; SRAM traffic sane.
  always @(negedge clk) begin
    logic push, pop;
    if (rst) begin
      q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      push = bus.in_valid && bus.in_ready;
      pop  = bus.out_valid && bus.out_ready;
      chk_eq("level", 32'(bus.level), 32'(q.size()));
      chk_eq("level_max", 32'(bus.level <= 9'd258), 32'd1);
      chk_eq("oeb", 32'(sram_oeb), 32'd0);
      chk_eq("web", 32'(sram_web), push ? 32'd0 : 32'd1);
      if (bus.out_valid) begin
        if (q.size() > 0) chk_eq("out_data", 32'(bus.out_data), 32'(q[0]));
        else              chk_eq("out_valid_empty", 32'(bus.out_valid), 32'd0);
      end
      if (pop && q.size() > 0) void'(q.pop_front());
      if (push) begin
        chk_eq("wr_csb", 32'(sram_csb), 32'd0);
        chk_eq("wr_addr", 32'(sram_a), wr_cnt % 256);
        chk_eq("wr_data", 32'(sram_i), 32'(bus.in_data));
        q.push_back(bus.in_data);
        wr_cnt++;
      end else if (!sram_csb) begin
        chk_eq("rd_addr", 32'(sram_a), rd_cnt % 256);
        chk_eq("rd_has_data", 32'(rd_cnt < wr_cnt), 32'd1);
        rd_cnt++;
      end
    end
  end

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 1200 && q.size() != 0; n++) tick();
    @(negedge clk);
    chk_eq(tag, 32'(bus.level), 32'd0);
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent, cyc, blocked, c, n;
    logic acc;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("rst_level", 32'(bus.level), 32'd0);
    chk_eq("rst_sram_ctl", 32'({sram_csb, sram_web, sram_oeb}), 32'b111);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk_eq("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Single word latency.
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    @(negedge clk);
    chk_eq("sw_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk_eq("sw_level", 32'(bus.level), 32'd1);
      chk_eq("sw_not_yet", 32'(bus.out_valid), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_eq("sw_valid", 32'(bus.out_valid), 32'd1);
    chk_eq("sw_data", 32'(bus.out_data), 32'hA5);
    chk_eq("sw_level3", 32'(bus.level), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk_eq("sw_level_after", 32'(bus.level), 32'd0);
    chk_eq("sw_valid_after", 32'(bus.out_valid), 32'd0);
    tick();

    // Fill to 258 words with the consumer stalled.
    for (int i = 0; i < 258; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      n = 0;
      do begin
        @(negedge clk);
        acc = bus.in_ready;
        tick();
        n++;
      end while (!acc && n < 10);
      if (!acc) chk_eq("fill_accept", 32'(acc), 32'd1);
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_eq("full_level", 32'(bus.level), 32'd258);
    chk_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("full_out_valid", 32'(bus.out_valid), 32'd1);
    chk_eq("full_head", 32'(bus.out_data), 32'h00);
    tick();
    drain("fill_drain");

    // Fairness: a refused push must go through on the following cycle.
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'($urandom);
    bus.out_ready = 1'b1;
    blocked = 0;
    acc = 1'b0;
    c = 0;
    while ((c < 100 || !acc) && c < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) begin
        chk_eq("fair_wait", 32'(blocked <= 1), 32'd1);
        blocked = 0;
      end else begin
        blocked++;
      end
      tick();
      if (acc) bus.in_data = 8'($urandom);
      c++;
    end
    bus.in_valid = 1'b0;
    drain("fair_drain");

    // Random traffic across pointer wrap.
    sent = 0;
    cyc  = 0;
    acc  = 1'b0;
    while (!(sent == 600 && q.size() == 0) && cyc < 20000) begin
      if (acc) bus.in_valid = 1'b0;
      if (!bus.in_valid && sent < 600 && $urandom_range(0, 2) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
      end
      if ((cyc / 300) % 3 == 1) bus.out_ready = ($urandom_range(0, 7) == 0);
      else                      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) sent++;
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk_eq("rand_sent", 32'(sent), 32'd600);
    chk_eq("rand_empty", 32'(q.size()), 32'd0);

    // Reset while a read is in flight.
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    @(negedge clk);
    chk_eq("rr_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_eq("rr_read_issued", 32'({sram_csb, sram_web}), 32'b01);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk_eq("rr_rst_ctl", 32'({sram_csb, sram_web, sram_oeb}), 32'b111);
    chk_eq("rr_rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_eq("rr_out_valid", 32'(bus.out_valid), 32'd0);
      chk_eq("rr_level", 32'(bus.level), 32'd0);
      tick();
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_eq("rr_new_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      tick();
    end
    chk_eq("rr_new_data", bus.out_valid ? 32'(bus.out_data) : 32'hFFF, 32'h77);
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk_eq("rr_final_level", 32'(bus.level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8: SRAM address width; depth = 2^AW = 256 words.
REQ-002 SHALL have parameter DW, default 8: word width, matching the 256x8 single-port SRAM macro.
REQ-003 clock  in  1  sole clock. All state updates on its rising edge. The SRAM macro's CE pin is tied to the same clock at integration.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  push request.
REQ-006 in_data  in  DW  push word.
REQ-007 in_ready  out  1  push accepted this cycle when in_valid && in_ready.
REQ-008 out_valid  out  1  head word available.
REQ-009 out_data  out  DW  head word.
REQ-010 out_ready  in  1  pop taken this cycle when out_valid && out_ready.
REQ-011 level  out  9  total words held: SRAM + in-flight read + output buffer, range 0..258.
REQ-012 sram_a  out  AW  SRAM address.
REQ-013 sram_i  out  DW  SRAM write data.
REQ-014 sram_csb  out  1  SRAM chip select, active low.
REQ-015 sram_web  out  1  SRAM write enable, active low.
REQ-016 sram_oeb  out  1  SRAM output enable, active low.
REQ-017 sram_o  in  DW  SRAM read data. Valid in the cycle after a read is issued.

Function
REQ-018 SHALL keep these counters:
- wr_ptr, rd_ptr: AW bits each, wrapping 255->0.
- mem_cnt: 0..256.
- inflight flag: 0/1.
- 2-entry output buffer (ob) with ob_cnt: 0..2.
REQ-019 SHALL issue at most one SRAM access per cycle: either a write (sram_csb=0, sram_web=0) or a read (sram_csb=0, sram_web=1). When idle, sram_csb=1 and sram_web=1.
REQ-020 Read issue condition, rd_issue = mem_cnt>0 && (ob_cnt + inflight) < 2 && !wr_owed. It SHALL NOT depend on in_valid.
REQ-021 in_ready SHALL equal !reset && mem_cnt<256 && !rd_issue.
REQ-022 On an accepted push:
- sram_a = wr_ptr, sram_i = in_data, write control active that cycle.
- wr_ptr advances by 1 at the clock edge.
REQ-023 On rd_issue:
- sram_a = rd_ptr.
- At the clock edge: rd_ptr advances, inflight is set, mem_cnt decrements.
REQ-024 When inflight is set:
- sram_o is captured into the ob tail at the next edge, and inflight clears unless a new read is issued.
- The ob must never overflow; the reservation in REQ-020 guarantees this.
REQ-025 out_valid = ob_cnt>0, and out_data = ob head. A pop removes the head; the ob shifts so that the second entry becomes the head.
REQ-026 wr_owed fairness rule:
- Set when in_valid && !in_ready && mem_cnt<256.
- Cleared on an accepted push.
- While set, it blocks reads so the next cycle is granted to the write.
REQ-027 mem_cnt SHALL increment on push, decrement on rd_issue, and stay unchanged when neither occurs.
REQ-028 level SHALL equal mem_cnt + inflight + ob_cnt after every edge.
REQ-029 Latency:
- Push accepted at edge E; the earliest read is issued in the cycle after E; data captured one edge later.
- Earliest out_valid is the third cycle after the push cycle when the FIFO starts empty.
REQ-030 Ordering SHALL be strict FIFO across pointer wrap-around. There is no bypass path around the SRAM.
REQ-031 Full (mem_cnt=256):
- in_ready=0 and no write is issued.
- Reads continue as ob space allows, which frees space for pushes.
REQ-032 Empty (mem_cnt=0): no read is issued, and out_valid reflects only the ob contents.
REQ-033 A pop and a capture in the same cycle SHALL leave ob_cnt unchanged and preserve order.
REQ-034 sram_oeb SHALL be 0 whenever reset is low.

Reset
REQ-035 While reset=1, the following hold at every edge:
- wr_ptr=0, rd_ptr=0, mem_cnt=0, inflight=0, ob_cnt=0, wr_owed=0.
- out_valid=0, in_ready=0, level=0.
- sram_csb=1, sram_web=1, sram_oeb=1.
REQ-036 Reset asserted mid-operation SHALL discard all held data, including an in-flight read. sram_o arriving in the cycle after reset SHALL be ignored.
REQ-037 In the first cycle after reset deasserts, in_ready=1 and out_valid=0.

Verification
REQ-038 Single word: push 0xA5 into an empty FIFO -> out_valid rises in the third cycle after the push with out_data=0xA5; level goes 1 throughout, then 0 after the pop.
REQ-039 Fill: push 0x00..0xFF plus 2 more with out_ready=0:
- After the ob fills (2 words), mem_cnt reaches 256 with level=258 and in_ready=0.
- Popping then returns all 258 words in order.
REQ-040 Wrap: run 600 words with random in_valid/out_ready -> output sequence equals input sequence; level never exceeds 258; no cycle has two SRAM accesses.
REQ-041 Fairness: hold in_valid=1 and out_ready=1 with a non-empty FIFO -> every push blocked by a read is accepted within 2 cycles.
REQ-042 Reset mid-read: assert reset in the cycle a read is in flight -> the next cycle shows out_valid=0 and level=0, and the stale sram_o never appears on out_data.
REQ-043 Simultaneous pop and capture with ob_cnt=1 -> ob_cnt stays 1 and the next out_data is the captured word.
